// File: rtl/bram36_pkg.sv
// Shared constants and address formatting for a RAMB36 used in 36-bit mode.
package bram36_pkg;

  localparam int RAM_DATA_W      = 32;
  localparam int RAM_PAR_W       = 4;
  localparam int RAM_ADDR_LSB    = 5;
  localparam int RAM_ADDR_PORT_W = 16;
  localparam int SKID_W          = RAM_DATA_W + RAM_PAR_W;

  // In 36-bit mode the word address sits at [..:5] of the 16-bit port; low bits stay 0.
  function automatic logic [RAM_ADDR_PORT_W-1:0] word_to_port(
    input logic [RAM_ADDR_PORT_W-1:0] word_addr
  );
    return word_addr << RAM_ADDR_LSB;
  endfunction

endpackage

// File: rtl/fifo_skid2.sv
// Two-entry skid buffer catching registered RAM read data; head drives the read stream.
module fifo_skid2
  import bram36_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              push_i,
  input  logic [SKID_W-1:0] din_i,
  input  logic              pop_i,
  output logic              valid_o,
  output logic [SKID_W-1:0] dout_o,
  output logic [1:0]        level_o
);

  logic [SKID_W-1:0] head_q;
  logic [SKID_W-1:0] tail_q;
  logic [1:0]        level_q;

  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      level_q <= 2'd0;
    end else begin
      case ({push_i, pop_i})
        2'b10: begin
          if (level_q == 2'd0) head_q <= din_i;
          else                 tail_q <= din_i;
          level_q <= level_q + 2'd1;
        end
        2'b01: begin
          head_q  <= tail_q;
          level_q <= level_q - 2'd1;
        end
        2'b11: begin
          if (level_q == 2'd2) begin
            head_q <= tail_q;
            tail_q <= din_i;
          end else begin
            head_q <= din_i;
          end
        end
        default: ;
      endcase
    end
  end

  assign valid_o = (level_q != 2'd0);
  assign dout_o  = head_q;
  assign level_o = level_q;

endmodule

// File: rtl/bram36_fifo_ctrl.sv
// FIFO controller in front of a RAMB36 (36-bit mode); skid buffer hides the 1-cycle read latency.
module bram36_fifo_ctrl
  import bram36_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        wr_valid,
  output logic                        wr_ready,
  input  logic [RAM_DATA_W-1:0]       wr_data,
  input  logic [RAM_PAR_W-1:0]        wr_par,
  output logic                        rd_valid,
  input  logic                        rd_ready,
  output logic [RAM_DATA_W-1:0]       rd_data,
  output logic [RAM_PAR_W-1:0]        rd_par,
  output logic [ADDR_W+1:0]           count,
  output logic [RAM_ADDR_PORT_W-1:0]  ram_addra,
  output logic [RAM_ADDR_PORT_W-1:0]  ram_addrb,
  output logic                        ram_ena,
  output logic [3:0]                  ram_wea,
  output logic [RAM_DATA_W-1:0]       ram_dia,
  output logic [RAM_PAR_W-1:0]        ram_dipa,
  output logic                        ram_enb,
  input  logic [RAM_DATA_W-1:0]       ram_dob,
  input  logic [RAM_PAR_W-1:0]        ram_dopb,
  output logic                        ram_ssra,
  output logic                        ram_ssrb,
  output logic [3:0]                  ram_web
);

  localparam int PW = ADDR_W + 1;
  localparam int CW = ADDR_W + 2;

  logic [ADDR_W:0]   wptr_q, wptr_d;
  logic [ADDR_W:0]   rptr_q, rptr_d;
  logic              inflight_q, inflight_d;
  logic [ADDR_W:0]   used;
  logic              wr_fire, rd_fire, issue;
  logic              skid_valid;
  logic [1:0]        level;
  logic [2:0]        occ;
  logic [SKID_W-1:0] head;

  // RAM occupancy never exceeds DEPTH, so its MSB alone flags "full".
  assign used     = wptr_q - rptr_q;
  assign wr_ready = !rst && !flush && !used[ADDR_W];
  assign wr_fire  = wr_valid && wr_ready;

  assign rd_valid = skid_valid && !rst;
  assign rd_fire  = rd_valid && rd_ready;

  // Skid slots spoken for after this cycle; counting the same-cycle pop keeps 1 word/cycle.
  assign occ   = {1'b0, level} + {2'b0, inflight_q} - {2'b0, rd_fire};
  assign issue = (wptr_q != rptr_q) && (occ < 3'd2) && !flush && !rst;

  always_comb begin
    wptr_d     = wptr_q + PW'(wr_fire);
    rptr_d     = flush ? wptr_q : rptr_q + PW'(issue);
    inflight_d = issue;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      inflight_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      inflight_q <= inflight_d;
    end
  end

  fifo_skid2 u_skid (
    .clk     (clk),
    .rst     (rst),
    .clear_i (flush),
    .push_i  (inflight_q),
    .din_i   ({ram_dopb, ram_dob}),
    .pop_i   (rd_fire),
    .valid_o (skid_valid),
    .dout_o  (head),
    .level_o (level)
  );

  assign rd_data = head[RAM_DATA_W-1:0];
  assign rd_par  = head[SKID_W-1:RAM_DATA_W];

  assign count = rst ? '0 : (CW'(used) + CW'(inflight_q) + CW'(level));

  assign ram_addra = word_to_port(RAM_ADDR_PORT_W'(wptr_q[ADDR_W-1:0]));
  assign ram_addrb = word_to_port(RAM_ADDR_PORT_W'(rptr_q[ADDR_W-1:0]));
  assign ram_ena   = wr_fire;
  assign ram_wea   = {4{wr_fire}};
  assign ram_dia   = wr_data;
  assign ram_dipa  = wr_par;
  assign ram_enb   = issue;
  assign ram_ssra  = 1'b0;
  assign ram_ssrb  = 1'b0;
  assign ram_web   = 4'h0;

endmodule

// File: tb/tb_bram36_fifo_ctrl.sv
// Directed bench for bram36_fifo_ctrl with a behavioural 1-cycle-latency RAM.
module tb_bram36_fifo_ctrl;

  localparam int ADDR_W = 10;

  logic        clk = 1'b0;
  logic        rst, flush, wr_valid, wr_ready, rd_valid, rd_ready;
  logic [31:0] wr_data, rd_data, ram_dia, ram_dob;
  logic [3:0]  wr_par, rd_par, ram_wea, ram_dipa, ram_dopb, ram_web;
  logic [ADDR_W+1:0] count;
  logic [15:0] ram_addra, ram_addrb;
  logic        ram_ena, ram_enb, ram_ssra, ram_ssrb;

  int tests = 0;
  int fails = 0;
  int acc, got, sent, cyc;
  logic saw_wrap;

  always #5 clk = ~clk;

  bram36_fifo_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_par(wr_par),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_par(rd_par),
    .count(count),
    .ram_addra(ram_addra), .ram_addrb(ram_addrb), .ram_ena(ram_ena), .ram_wea(ram_wea),
    .ram_dia(ram_dia), .ram_dipa(ram_dipa), .ram_enb(ram_enb),
    .ram_dob(ram_dob), .ram_dopb(ram_dopb),
    .ram_ssra(ram_ssra), .ram_ssrb(ram_ssrb), .ram_web(ram_web)
  );

  logic [35:0] mem [0:1023];
  always @(posedge clk) begin
    if (ram_ena && ram_wea == 4'hF) mem[ram_addra[14:5]] <= {ram_dipa, ram_dia};
    if (ram_enb) {ram_dopb, ram_dob} <= mem[ram_addrb[14:5]];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; flush = 0; wr_valid = 0; wr_data = 0; wr_par = 0; rd_ready = 0;
    #1;
    chk("rst0_wr_ready", wr_ready, 0);
    chk("rst0_rd_valid", rd_valid, 0);
    chk("rst0_count", count, 0);
    chk("rst0_ram_ena", ram_ena, 0);
    step();
    #1;
    chk("rst1_wr_ready", wr_ready, 0);
    chk("rst1_count", count, 0);
    chk("rst1_ram_enb", ram_enb, 0);
    chk("rst1_ssr_web", {ram_ssra, ram_ssrb, ram_web}, 0);

    // single word latency: write in cycle 2, visible in cycle 5
    step();
    rst = 0; wr_valid = 1; wr_data = 32'hDEADBEEF; wr_par = 4'hA;
    #1;
    chk("c2_wr_ready", wr_ready, 1);
    chk("c2_ram_ena", ram_ena, 1);
    chk("c2_ram_wea", ram_wea, 4'hF);
    chk("c2_ram_addra", ram_addra, 16'h0000);
    chk("c2_ram_dia", {ram_dipa, ram_dia}, 36'hADEADBEEF);
    chk("c2_count", count, 0);
    step();
    wr_valid = 0;
    #1;
    chk("c3_count", count, 1);
    chk("c3_ram_enb", ram_enb, 1);
    chk("c3_ram_addrb", ram_addrb, 16'h0000);
    chk("c3_rd_valid", rd_valid, 0);
    step();
    #1;
    chk("c4_rd_valid", rd_valid, 0);
    chk("c4_count", count, 1);
    chk("c4_ram_enb", ram_enb, 0);
    step();
    rd_ready = 1;
    #1;
    chk("c5_rd_valid", rd_valid, 1);
    chk("c5_rd_data", rd_data, 32'hDEADBEEF);
    chk("c5_rd_par", rd_par, 4'hA);
    chk("c5_count", count, 1);
    step();
    rd_ready = 0;
    #1;
    chk("c6_rd_valid", rd_valid, 0);
    chk("c6_count", count, 0);

    // 8-word burst from fresh pointers, rd_ready held high
    rst = 1; step(); step(); rst = 0; rd_ready = 1;
    for (int c = 0; c < 14; c++) begin
      wr_valid = (c < 8); wr_data = c; wr_par = c[3:0];
      #1;
      chk("burst_enb", ram_enb, (c >= 1 && c < 9));
      if (c >= 1 && c < 9) chk("burst_addrb", ram_addrb, 16'((c - 1) * 32));
      chk("burst_valid", rd_valid, (c >= 3 && c < 11));
      if (c >= 3 && c < 11) chk("burst_data", rd_data, c - 3);
      step();
    end
    wr_valid = 0;
    #1;
    chk("burst_count_end", count, 0);

    // fill to DEPTH+2 with reads stalled
    rst = 1; step(); step(); rst = 0; rd_ready = 0;
    acc = 0; cyc = 0; wr_valid = 1;
    while (acc < 1026 && cyc < 3000) begin
      wr_data = 32'h1000_0000 + acc; wr_par = acc[3:0];
      #1;
      if (wr_ready) acc++;
      step();
      cyc++;
    end
    chk("full_accepted", acc, 1026);
    #1;
    chk("full_wr_ready", wr_ready, 0);
    chk("full_ram_ena", ram_ena, 0);
    chk("full_count", count, 1026);
    step();
    #1;
    chk("full_hold_wr_ready", wr_ready, 0);
    chk("full_hold_count", count, 1026);
    wr_valid = 0; rd_ready = 1;
    got = 0; cyc = 0;
    while (got < 1026 && cyc < 3000) begin
      #1;
      if (rd_valid) begin
        chk("drain_data", rd_data, 32'h1000_0000 + got);
        chk("drain_par", rd_par, got % 16);
        got++;
      end
      step();
      cyc++;
    end
    chk("drain_got", got, 1026);
    #1;
    chk("drain_count", count, 0);
    chk("drain_rd_valid", rd_valid, 0);

    // continuous push/pop across the 1023 -> 0 address wrap
    sent = 0; got = 0; cyc = 0; saw_wrap = 0; rd_ready = 1;
    while (got < 1500 && cyc < 4000) begin
      wr_valid = (sent < 1500); wr_data = 32'hA000_0000 + sent; wr_par = sent[3:0];
      #1;
      if (rd_valid) begin
        chk("wrap_data", rd_data, 32'hA000_0000 + got);
        got++;
      end
      if (wr_valid && wr_ready) begin
        if (ram_addra == 16'h0000) saw_wrap = 1;
        sent++;
      end
      step();
      cyc++;
    end
    wr_valid = 0;
    chk("wrap_got", got, 1500);
    chk("wrap_addra_zero", saw_wrap, 1);
    #1;
    chk("wrap_count", count, 0);

    // flush with one word buffered and one read in flight
    step();
    rd_ready = 0; wr_valid = 1; wr_data = 32'h11; wr_par = 4'h1;
    step();
    wr_data = 32'h22; wr_par = 4'h2;
    step();
    wr_valid = 0;
    step();
    #1;
    chk("pre_flush_count", count, 2);
    flush = 1; wr_valid = 1; wr_data = 32'h77;
    #1;
    chk("flush_wr_ready", wr_ready, 0);
    chk("flush_ram_ena", ram_ena, 0);
    chk("flush_ram_enb", ram_enb, 0);
    step();
    flush = 0; wr_valid = 0;
    #1;
    chk("post_flush_rd_valid", rd_valid, 0);
    chk("post_flush_count", count, 0);
    step();
    #1;
    chk("post_flush2_rd_valid", rd_valid, 0);
    chk("post_flush2_count", count, 0);
    wr_valid = 1; wr_data = 32'h55; wr_par = 4'h5;
    step();
    wr_valid = 0;
    step(); step();
    #1;
    chk("after_flush_valid", rd_valid, 1);
    chk("after_flush_data", rd_data, 32'h55);
    chk("after_flush_par", rd_par, 4'h5);
    rd_ready = 1;
    step();
    rd_ready = 0;
    #1;
    chk("after_flush_empty", count, 0);

    // reset while count=5 and a read is in flight
    step();
    for (int c = 0; c < 6; c++) begin
      wr_valid = 1; wr_data = 32'hC0 + c; wr_par = 4'h0; rd_ready = (c == 5);
      #1;
      step();
    end
    wr_valid = 0; rd_ready = 0;
    #1;
    chk("pre_rst_count", count, 5);
    rst = 1;
    #1;
    chk("in_rst_count", count, 0);
    chk("in_rst_rd_valid", rd_valid, 0);
    chk("in_rst_wr_ready", wr_ready, 0);
    step();
    rst = 0;
    #1;
    chk("rel_count", count, 0);
    chk("rel_rd_valid", rd_valid, 0);
    chk("rel_wr_ready", wr_ready, 1);
    chk("rel_ram_enb", ram_enb, 0);
    rd_ready = 1;
    for (int c = 0; c < 5; c++) begin
      step();
      #1;
      chk("rel_no_stale", rd_valid, 0);
    end
    rd_ready = 0; wr_valid = 1; wr_data = 32'h99; wr_par = 4'h9;
    step();
    wr_valid = 0;
    step(); step();
    #1;
    chk("rel_first_valid", rd_valid, 1);
    chk("rel_first_data", rd_data, 32'h99);
    chk("rel_first_count", count, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
